bits32_8word_splitter: RTL and testbench

//   Upstream companion of the 8b->32b word packer: takes 32-bit words and emits

---
 rtl/bits32_8word_splitter_pkg.sv | 22 ++
 rtl/bits32_8word_splitter_word_fifo.sv | 62 ++++++
 rtl/bits32_8word_splitter.sv | 120 ++++++++++++
 tb/tb_bits32_8word_splitter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bits32_8word_splitter_pkg.sv
// Shared widths and FSM encoding for the 32b->8b word splitter.
// The 8b->32b packer uses the same byte/word widths.
package bits32_8word_splitter_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Most significant byte of a word (the byte sent first).
   function automatic logic [BYTE_W-1:0] msb_byte(
      input logic [WORD_W-1:0] w
   );
      return w[WORD_W-1 -: BYTE_W];
   endfunction

endpackage

// File: rtl/bits32_8word_splitter_word_fifo.sv
// Word FIFO for the splitter: DEPTH x WORD_W, head shown combinationally.
// Ports: clk, reset (async high), push, pop, din, dout, empty, full, count.
module word_fifo #(
   parameter int DEPTH  = 2,
   parameter int WORD_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WORD_W-1:0]        din,
   output logic [WORD_W-1:0]        dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/bits32_8word_splitter.sv
// 32-bit word to 8-bit byte stream splitter, MSB byte first.
// Ports: clk_4f, reset, valid_in, Data_in, ready_out, valid_out, Data_out, last_byte.
module bits32_8word_splitter
   import bits32_8word_splitter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk_4f,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [WORD_W-1:0] Data_in,
   output logic              ready_out,
   output logic              valid_out,
   output logic [BYTE_W-1:0] Data_out,
   output logic              last_byte
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(BYTES_PER_WORD - 1);

   state_e             state_q, state_d;
   logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
   logic [WORD_W-1:0]  shift_q, shift_d;
   logic               vld_q, vld_d;
   logic [BYTE_W-1:0]  data_q, data_d;
   logic               last_q, last_d;

   logic               fifo_push, fifo_pop, load;
   logic               fifo_empty, fifo_full;
   logic [WORD_W-1:0]  fifo_dout;
   logic [CNT_W-1:0]   fifo_count;

   // Readiness comes from the registered count only, so a pop on the
   // same edge never opens a slot for a same-edge push.
   assign ready_out = (fifo_count != CNT_W'(DEPTH));
   assign fifo_push = valid_in && ready_out && !fifo_full;

   word_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_fifo (
      .clk   (clk_4f),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (Data_in),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // The output register always holds the byte being presented;
   // shift_q holds the bytes of the current word still to come.
   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      shift_d  = shift_q;
      vld_d    = vld_q;
      data_d   = data_q;
      last_d   = last_q;
      load     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         ST_SEND: begin
            if (bcnt_q == LAST_CNT) begin
               // Chain straight into the next word when one is queued.
               if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  vld_d   = 1'b0;
                  data_d  = '0;
                  last_d  = 1'b0;
               end
            end else begin
               data_d  = msb_byte(shift_q);
               shift_d = shift_q << BYTE_W;
               bcnt_d  = bcnt_q + 1'b1;
               last_d  = (bcnt_q == LAST_CNT - 1'b1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         state_d = ST_SEND;
         data_d  = msb_byte(fifo_dout);
         shift_d = fifo_dout << BYTE_W;
         bcnt_d  = '0;
         vld_d   = 1'b1;
         last_d  = 1'b0;
      end
      fifo_pop = load;
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         bcnt_q  <= '0;
         shift_q <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_out = vld_q;
   assign Data_out  = data_q;
   assign last_byte = last_q;

endmodule

// File: tb/tb_bits32_8word_splitter.sv
// Directed testbench for bits32_8word_splitter (DEPTH=2).
// Includes a behavioural 8b->32b packer for the loopback scenario.
module tb_bits32_8word_splitter;

   logic        clk_4f = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] Data_in;
   logic        ready_out;
   logic        valid_out;
   logic [7:0]  Data_out;
   logic        last_byte;

   int checks = 0;
   int errors = 0;

   bits32_8word_splitter #(.DEPTH(2)) dut (
      .clk_4f    (clk_4f),
      .reset     (reset),
      .valid_in  (valid_in),
      .Data_in   (Data_in),
      .ready_out (ready_out),
      .valid_out (valid_out),
      .Data_out  (Data_out),
      .last_byte (last_byte)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic tick;
      @(posedge clk_4f);
      #1;
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      valid_in = 1'b0;
      Data_in  = '0;
      #12;
      checks++;
      if (valid_out !== 1'b0 || Data_out !== 8'h00 || last_byte !== 1'b0) begin
         errors++;
         $display("FAIL rst_out: v=%b d=%h l=%b want 0 00 0",
                  valid_out, Data_out, last_byte);
      end
      @(posedge clk_4f);
      #3 reset = 1'b0;
      tick();
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready: got %b want 1", ready_out);
      end
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL rst_idle: valid_out %b want 0", valid_out);
      end
   endtask

   task automatic test_single;
      logic [7:0] exp [4];
      exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      valid_in = 1'b1;
      Data_in  = 32'hA1B2C3D4;
      tick();
      valid_in = 1'b0;
      Data_in  = '0;
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL single_lat: valid_out %b want 0", valid_out);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (valid_out !== 1'b1 || Data_out !== exp[i] ||
             last_byte !== (i == 3)) begin
            errors++;
            $display("FAIL single_b%0d: v=%b d=%h l=%b want 1 %h %b",
                     i, valid_out, Data_out, last_byte, exp[i], i == 3);
         end
      end
      tick();
      checks++;
      if (valid_out !== 1'b0 || Data_out !== 8'h00 || last_byte !== 1'b0) begin
         errors++;
         $display("FAIL single_end: v=%b d=%h l=%b want 0 00 0",
                  valid_out, Data_out, last_byte);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp;
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rdy0: got %b want 1", ready_out);
      end
      valid_in = 1'b1;
      Data_in  = 32'h01020304;
      tick();
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rdy1: got %b want 1", ready_out);
      end
      Data_in = 32'h05060708;
      tick();
      valid_in = 1'b0;
      Data_in  = '0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) tick();
         exp = 8'(i + 1);
         checks++;
         if (valid_out !== 1'b1 || Data_out !== exp ||
             last_byte !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL b2b_b%0d: v=%b d=%h l=%b want 1 %h %b",
                     i, valid_out, Data_out, last_byte, exp, i % 4 == 3);
         end
      end
      tick();
      checks++;
      if (valid_out !== 1'b0 || Data_out !== 8'h00) begin
         errors++;
         $display("FAIL b2b_end: v=%b d=%h want 0 00", valid_out, Data_out);
      end
   endtask

   task automatic test_burst;
      logic [31:0] w [5];
      logic [7:0]  got [$];
      logic [7:0]  exp;
      logic        acc;
      int          idx = 0;
      int          nlast = 0;
      bit          saw_low = 0;
      w = '{32'h10111213, 32'h20212223, 32'h30313233,
            32'h40414243, 32'h50515253};
      for (int c = 0; c < 60; c++) begin
         valid_in = (idx < 5);
         if (idx < 5) Data_in = w[idx];
         else         Data_in = '0;
         if (!ready_out) saw_low = 1;
         acc = valid_in && ready_out;
         tick();
         if (acc) idx++;
         if (valid_out) begin
            got.push_back(Data_out);
            if (last_byte) nlast++;
         end
      end
      valid_in = 1'b0;
      checks++;
      if (!saw_low) begin
         errors++;
         $display("FAIL burst_rdy: ready_out never dropped, want drop");
      end
      checks++;
      if (idx != 5) begin
         errors++;
         $display("FAIL burst_push: pushed %0d want 5", idx);
      end
      checks++;
      if (got.size() != 20 || nlast != 5) begin
         errors++;
         $display("FAIL burst_cnt: bytes %0d lasts %0d want 20 5",
                  got.size(), nlast);
      end
      for (int j = 0; j < 20 && j < got.size(); j++) begin
         exp = 8'(w[j / 4] >> (8 * (3 - (j % 4))));
         checks++;
         if (got[j] !== exp) begin
            errors++;
            $display("FAIL burst_b%0d: got %h want %h", j, got[j], exp);
         end
      end
   endtask

   task automatic test_reset_midword;
      logic [7:0] exp [4];
      int bad = 0;
      exp = '{8'h11, 8'h22, 8'h33, 8'h44};
      valid_in = 1'b1;
      Data_in  = 32'hDEADBEEF;
      tick();
      Data_in = 32'hCAFEBABE;
      tick();
      valid_in = 1'b0;
      Data_in  = '0;
      tick();
      checks++;
      if (valid_out !== 1'b1 || Data_out !== 8'hAD) begin
         errors++;
         $display("FAIL mid_pre: v=%b d=%h want 1 ad", valid_out, Data_out);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (valid_out !== 1'b0 || Data_out !== 8'h00 || last_byte !== 1'b0) begin
         errors++;
         $display("FAIL mid_async: v=%b d=%h l=%b want 0 00 0",
                  valid_out, Data_out, last_byte);
      end
      @(posedge clk_4f);
      #3 reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (valid_out !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_quiet: %0d valid bytes after reset want 0", bad);
      end
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL mid_rdy: got %b want 1", ready_out);
      end
      valid_in = 1'b1;
      Data_in  = 32'h11223344;
      tick();
      valid_in = 1'b0;
      Data_in  = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (valid_out !== 1'b1 || Data_out !== exp[i] ||
             last_byte !== (i == 3)) begin
            errors++;
            $display("FAIL mid_b%0d: v=%b d=%h l=%b want 1 %h %b",
                     i, valid_out, Data_out, last_byte, exp[i], i == 3);
         end
      end
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL mid_end: valid_out %b want 0", valid_out);
      end
   endtask

   task automatic test_loopback;
      logic [31:0] words [64];
      logic [31:0] pk = '0;
      logic        acc;
      int          sidx = 0;
      int          rcv = 0;
      int          nb = 0;
      for (int i = 0; i < 64; i++) words[i] = $urandom;
      for (int c = 0; c < 2000 && rcv < 64; c++) begin
         valid_in = (sidx < 64) && ($urandom_range(0, 3) != 0);
         if (sidx < 64) Data_in = words[sidx];
         else           Data_in = '0;
         acc = valid_in && ready_out;
         tick();
         if (acc) sidx++;
         if (valid_out) begin
            pk = {pk[23:0], Data_out};
            nb++;
            if (nb == 4) begin
               checks++;
               if (pk !== words[rcv] || last_byte !== 1'b1) begin
                  errors++;
                  $display("FAIL loop_w%0d: got %h l=%b want %h 1",
                           rcv, pk, last_byte, words[rcv]);
               end
               rcv++;
               nb = 0;
            end else if (last_byte) begin
               checks++;
               errors++;
               $display("FAIL loop_last: last_byte at byte %0d want 3", nb - 1);
            end
         end
      end
      valid_in = 1'b0;
      checks++;
      if (rcv != 64) begin
         errors++;
         $display("FAIL loop_cnt: received %0d words want 64", rcv);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_burst();
      test_reset_midword();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
